interrupt_sequencer: RTL and testbench

Sequences hardware interrupt entry for the 16-bit pipelined RISC core. Sits beside the decode stage and control unit. Latches `interrupt_signal`, waits for a safe point, stalls fetch and drains the pipeline, then pushes the 32-bit return PC and flags through the 16-bit memory stage. It reads the 32-bit handler vector from data memory and redirects the PC. It owns the fetch stall and memory-stage injection for the whole interrupt entry sequence.

---
 rtl/interrupt_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Interrupt entry sequencer for the 16-bit pipelined RISC core. It latches a
// request and waits until no control transfer is in flight. It then stalls
// fetch and drains the pipeline for a fixed number of cycles. Next it pushes
// the 32-bit return PC (high half, then low half) and the flags through the
// memory stage. It reads the 32-bit handler vector from data memory and loads
// it into the PC.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset
//   interrupt_signal  interrupt request, a one-cycle pulse suffices
//   branch_pending    control transfer in flight; defers entry from IDLE only
//   pc_current        PC of next unexecuted instruction (return address)
//   flags_in          current flag register (Z, N, C)
//   mem_rd_data       data-memory read data, valid one cycle after mem_rd_en
//   stall_fetch       hold PC and IF/ID, insert bubbles into decode
//   push_en           inject a stack push in the memory stage
//   push_data         word to push
//   mem_rd_en         vector read request
//   mem_rd_addr       vector read address
//   pc_load           load pc_load_value into the PC
//   pc_load_value     handler address
//   int_ack           one-cycle pulse when entry completes
//   busy              sequencer not idle
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
    parameter logic [31:0] VECTOR_ADDR  = 32'h0,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned FLAG_W       = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              interrupt_signal,
    input  logic              branch_pending,
    input  logic [31:0]       pc_current,
    input  logic [FLAG_W-1:0] flags_in,
    input  logic [15:0]       mem_rd_data,
    output logic              stall_fetch,
    output logic              push_en,
    output logic [15:0]       push_data,
    output logic              mem_rd_en,
    output logic [31:0]       mem_rd_addr,
    output logic              pc_load,
    output logic [31:0]       pc_load_value,
    output logic              int_ack,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    // Last drain count value before moving on; zero drain cycles still spends
    // one cycle in DRAIN.
    localparam logic [CNT_W-1:0] DRAIN_LAST =
        CNT_W'((DRAIN_CYCLES == 32'd0) ? 32'd0 : (DRAIN_CYCLES - 32'd1));

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        PUSH_HI  = 3'd2,
        PUSH_LO  = 3'd3,
        PUSH_FLG = 3'd4,
        VEC_HI   = 3'd5,
        VEC_LO   = 3'd6,
        LOAD     = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic               pend_q, pend_d;
    logic               again_q, again_d;
    logic               int_prev_q, int_prev_d;
    logic [31:0]        ret_pc_q, ret_pc_d;
    logic [15:0]        vec_hi_q, vec_hi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               leave_load;
    logic               req_rise;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            again_q    <= 1'b0;
            int_prev_q <= 1'b0;
            ret_pc_q   <= 32'h0;
            vec_hi_q   <= 16'h0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            again_q    <= again_d;
            int_prev_q <= int_prev_d;
            ret_pc_q   <= ret_pc_d;
            vec_hi_q   <= vec_hi_d;
            cnt_q      <= cnt_d;
        end
    end

    // Pending-request bookkeeping.
    // pend is cleared when LOAD completes unless the request line is high in
    // that cycle. A fresh request edge seen while busy is remembered in again
    // so it survives that clear. A level held across a whole sequence is the
    // same request, so it does not re-arm again.
    always_comb begin
        leave_load = (state_q == LOAD);
        req_rise   = interrupt_signal && !int_prev_q;
        int_prev_d = interrupt_signal;

        pend_d  = pend_q || interrupt_signal;
        again_d = again_q || (req_rise && (state_q != IDLE));

        if (leave_load) begin
            pend_d  = interrupt_signal || again_q;
            again_d = 1'b0;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d       = state_q;
        ret_pc_d      = ret_pc_q;
        vec_hi_d      = vec_hi_q;
        cnt_d         = cnt_q;
        push_en       = 1'b0;
        push_data     = 16'h0;
        mem_rd_en     = 1'b0;
        mem_rd_addr   = 32'h0;
        pc_load       = 1'b0;
        pc_load_value = 32'h0;
        int_ack       = 1'b0;
        stall_fetch   = (state_q != IDLE);
        busy          = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (pend_q && !branch_pending) begin
                    state_d  = DRAIN;
                    ret_pc_d = pc_current;
                    cnt_d    = '0;
                end
            end

            DRAIN: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q >= DRAIN_LAST) begin
                    state_d = PUSH_HI;
                end
            end

            PUSH_HI: begin
                push_en   = 1'b1;
                push_data = ret_pc_q[31:16];
                state_d   = PUSH_LO;
            end

            PUSH_LO: begin
                push_en   = 1'b1;
                push_data = ret_pc_q[15:0];
                state_d   = PUSH_FLG;
            end

            // Flags are taken live this cycle, zero-extended to a word.
            PUSH_FLG: begin
                push_en   = 1'b1;
                push_data = 16'(flags_in);
                state_d   = VEC_HI;
            end

            VEC_HI: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = VECTOR_ADDR;
                state_d     = VEC_LO;
            end

            // Read data here answers the VEC_HI request.
            VEC_LO: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = VECTOR_ADDR + 32'd1;
                vec_hi_d    = mem_rd_data;
                state_d     = LOAD;
            end

            // Read data here answers the VEC_LO request.
            LOAD: begin
                pc_load       = 1'b1;
                pc_load_value = {vec_hi_q, mem_rd_data};
                int_ack       = 1'b1;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
`timescale 1ns/1ps
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        interrupt_signal;
    logic        branch_pending;
    logic [31:0] pc_current;
    logic [2:0]  flags_in;

    logic [15:0] mem_rd_data   [2];
    logic        stall_fetch   [2];
    logic        push_en       [2];
    logic [15:0] push_data     [2];
    logic        mem_rd_en     [2];
    logic [31:0] mem_rd_addr   [2];
    logic        pc_load       [2];
    logic [31:0] pc_load_value [2];
    logic        int_ack       [2];
    logic        busy          [2];

    logic [15:0] mem0 [4];
    logic [15:0] mem1 [4];

    int errors = 0;
    int checks = 0;
    int ack_cnt  [2] = '{0, 0};
    int load_cnt [2] = '{0, 0};
    int a0;
    int l0;

    interrupt_sequencer u0 (
        .clk              (clk),
        .reset            (reset),
        .interrupt_signal (interrupt_signal),
        .branch_pending   (branch_pending),
        .pc_current       (pc_current),
        .flags_in         (flags_in),
        .mem_rd_data      (mem_rd_data[0]),
        .stall_fetch      (stall_fetch[0]),
        .push_en          (push_en[0]),
        .push_data        (push_data[0]),
        .mem_rd_en        (mem_rd_en[0]),
        .mem_rd_addr      (mem_rd_addr[0]),
        .pc_load          (pc_load[0]),
        .pc_load_value    (pc_load_value[0]),
        .int_ack          (int_ack[0]),
        .busy             (busy[0])
    );

    interrupt_sequencer #(
        .VECTOR_ADDR  (32'hFFFF_FFFF),
        .DRAIN_CYCLES (0)
    ) u1 (
        .clk              (clk),
        .reset            (reset),
        .interrupt_signal (interrupt_signal),
        .branch_pending   (branch_pending),
        .pc_current       (pc_current),
        .flags_in         (flags_in),
        .mem_rd_data      (mem_rd_data[1]),
        .stall_fetch      (stall_fetch[1]),
        .push_en          (push_en[1]),
        .push_data        (push_data[1]),
        .mem_rd_en        (mem_rd_en[1]),
        .mem_rd_addr      (mem_rd_addr[1]),
        .pc_load          (pc_load[1]),
        .pc_load_value    (pc_load_value[1]),
        .int_ack          (int_ack[1]),
        .busy             (busy[1])
    );

    // Data memories with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en[0]) mem_rd_data[0] <= mem0[mem_rd_addr[0][1:0]];
        if (mem_rd_en[1]) mem_rd_data[1] <= mem1[mem_rd_addr[1][1:0]];
    end

    // Count completion and PC-load pulses mid-cycle.
    always @(negedge clk) begin
        if (int_ack[0]) ack_cnt[0]++;
        if (int_ack[1]) ack_cnt[1]++;
        if (pc_load[0]) load_cnt[0]++;
        if (pc_load[1]) load_cnt[1]++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int n, input string tag);
        chk({tag, "_stall"},  32'(stall_fetch[n]),   32'd0);
        chk({tag, "_busy"},   32'(busy[n]),          32'd0);
        chk({tag, "_push"},   32'(push_en[n]),       32'd0);
        chk({tag, "_pdata"},  32'(push_data[n]),     32'd0);
        chk({tag, "_rd"},     32'(mem_rd_en[n]),     32'd0);
        chk({tag, "_raddr"},  mem_rd_addr[n],        32'd0);
        chk({tag, "_pcld"},   32'(pc_load[n]),       32'd0);
        chk({tag, "_pcval"},  pc_load_value[n],      32'd0);
        chk({tag, "_ack"},    32'(int_ack[n]),       32'd0);
    endtask

    // Called just after the edge that should enter DRAIN; returns just after
    // the edge that leaves LOAD.
    task automatic expect_entry(input int n, input int drain, input logic [31:0] ret,
                                input logic [2:0] fl, input logic [31:0] va,
                                input logic [31:0] handler);
        for (int d = 0; d < drain; d++) begin
            chk("drain_busy",  32'(busy[n]),        32'd1);
            chk("drain_stall", 32'(stall_fetch[n]), 32'd1);
            chk("drain_push",  32'(push_en[n]),     32'd0);
            tick();
        end
        chk("push_hi_en",   32'(push_en[n]),   32'd1);
        chk("push_hi_data", 32'(push_data[n]), 32'(ret[31:16]));
        tick();
        chk("push_lo_en",   32'(push_en[n]),   32'd1);
        chk("push_lo_data", 32'(push_data[n]), 32'(ret[15:0]));
        tick();
        chk("push_flg_en",   32'(push_en[n]),   32'd1);
        chk("push_flg_data", 32'(push_data[n]), 32'(fl));
        chk("push_flg_rd",   32'(mem_rd_en[n]), 32'd0);
        tick();
        chk("vec_hi_rd",    32'(mem_rd_en[n]), 32'd1);
        chk("vec_hi_addr",  mem_rd_addr[n],    va);
        chk("vec_hi_push",  32'(push_en[n]),   32'd0);
        tick();
        chk("vec_lo_rd",    32'(mem_rd_en[n]), 32'd1);
        chk("vec_lo_addr",  mem_rd_addr[n],    va + 32'd1);
        tick();
        chk("load_pcld",    32'(pc_load[n]),     32'd1);
        chk("load_ack",     32'(int_ack[n]),     32'd1);
        chk("load_value",   pc_load_value[n],    handler);
        chk("load_stall",   32'(stall_fetch[n]), 32'd1);
        chk("load_rd",      32'(mem_rd_en[n]),   32'd0);
        tick();
        chk("after_busy",   32'(busy[n]),          32'd0);
        chk("after_pcld",   32'(pc_load[n]),       32'd0);
        chk("after_pcval",  pc_load_value[n],      32'd0);
        chk("after_raddr",  mem_rd_addr[n],        32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        interrupt_signal = 1'b0;
        branch_pending   = 1'b0;
        pc_current       = 32'h0000_1234;
        flags_in         = 3'b101;
        mem0[0] = 16'h0000; mem0[1] = 16'h0200; mem0[2] = 16'h0000; mem0[3] = 16'h0000;
        mem1[3] = 16'hABCD; mem1[0] = 16'h0042; mem1[1] = 16'h0000; mem1[2] = 16'h0000;

        // Reset state.
        repeat (3) tick();
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        reset = 1'b0;
        repeat (2) tick();

        // Basic entry on both instances; u1 has zero drain and a wrapping vector.
        a0 = ack_cnt[0];
        interrupt_signal = 1'b1;
        tick();
        interrupt_signal = 1'b0;
        chk("basic_idle_after_req0", 32'(busy[0]), 32'd0);
        chk("basic_idle_after_req1", 32'(busy[1]), 32'd0);
        tick();
        fork
            expect_entry(0, 3, 32'h0000_1234, 3'b101, 32'h0000_0000, 32'h0000_0200);
            expect_entry(1, 1, 32'h0000_1234, 3'b101, 32'hFFFF_FFFF, 32'hABCD_0042);
        join
        chk("basic_ack_count", 32'(ack_cnt[0] - a0), 32'd1);
        repeat (4) tick();

        // Deferral by branch_pending; return PC taken at the entry edge.
        interrupt_signal = 1'b1;
        branch_pending   = 1'b1;
        tick();
        interrupt_signal = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pc_current = 32'h5555_0000 + 32'(k);
            tick();
            chk("defer_idle", 32'(busy[0]), 32'd0);
        end
        branch_pending = 1'b0;
        pc_current     = 32'h5555_AAAA;
        tick();
        pc_current     = 32'h0000_0000;
        branch_pending = 1'b1;
        expect_entry(0, 3, 32'h5555_AAAA, 3'b101, 32'h0000_0000, 32'h0000_0200);
        branch_pending = 1'b0;
        pc_current     = 32'h0000_1234;
        repeat (4) tick();

        // Back-to-back: second pulse during PUSH_LO.
        a0 = ack_cnt[0];
        interrupt_signal = 1'b1;
        tick();
        interrupt_signal = 1'b0;
        tick();
        fork
            begin
                expect_entry(0, 3, 32'h0000_1234, 3'b101, 32'h0, 32'h0000_0200);
                tick();
                expect_entry(0, 3, 32'h0000_1234, 3'b101, 32'h0, 32'h0000_0200);
            end
            begin
                repeat (4) tick();
                interrupt_signal = 1'b1;
                tick();
                interrupt_signal = 1'b0;
            end
        join
        repeat (12) tick();
        chk("b2b_ack_count", 32'(ack_cnt[0] - a0), 32'd2);
        chk("b2b_idle_end",  32'(busy[0]),         32'd0);

        // Request held for 20 edges: exactly two sequences.
        a0 = ack_cnt[0];
        interrupt_signal = 1'b1;
        tick();
        tick();
        fork
            begin
                expect_entry(0, 3, 32'h0000_1234, 3'b101, 32'h0, 32'h0000_0200);
                tick();
                expect_entry(0, 3, 32'h0000_1234, 3'b101, 32'h0, 32'h0000_0200);
            end
            begin
                repeat (18) tick();
                interrupt_signal = 1'b0;
            end
        join
        repeat (12) tick();
        chk("held_ack_count", 32'(ack_cnt[0] - a0), 32'd2);
        chk("held_idle_end",  32'(busy[0]),         32'd0);

        // Reset during VEC_HI abandons the sequence; a fresh request works.
        l0 = load_cnt[0];
        a0 = ack_cnt[0];
        interrupt_signal = 1'b1;
        tick();
        interrupt_signal = 1'b0;
        repeat (7) tick();
        chk("pre_reset_vec_hi", 32'(mem_rd_en[0]), 32'd1);
        reset = 1'b1;
        #1;
        check_zero(0, "mid_reset");
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("reset_no_load", 32'(load_cnt[0] - l0), 32'd0);
        chk("reset_no_ack",  32'(ack_cnt[0] - a0),  32'd0);
        chk("reset_idle",    32'(busy[0]),          32'd0);
        interrupt_signal = 1'b1;
        tick();
        interrupt_signal = 1'b0;
        tick();
        expect_entry(0, 3, 32'h0000_1234, 3'b101, 32'h0, 32'h0000_0200);
        chk("post_reset_load", 32'(load_cnt[0] - l0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
